// File: rtl/seg_pkg.sv
// Shared definitions for the 74HC595 seven-segment display link: segment table,
// word geometry and the segment-to-nibble decoder.
package seg_pkg;

  localparam int WORD_W = 16;
  localparam int DIGITS = 8;

  typedef logic [31:0] u32;

  // Active-low segment patterns for 0..F; bit0 is the decimal point (1 = off)
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'h03, 8'h9f, 8'h25, 8'h0d, 8'h99, 8'h49, 8'h41, 8'h1f,
    8'h01, 8'h09, 8'h11, 8'hc1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  function automatic logic [4:0] seg2nib(input logic [7:0] seg);
    logic [4:0] res;
    res = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        res = {1'b1, 4'(i)};
      end
    end
    return res;
  endfunction

  function automatic logic is_onehot8(input logic [7:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + int'(v[i]);
    end
    return (ones == 1);
  endfunction

  // Digit index for a one-hot segbit: bit 7 selects digit 0
  function automatic logic [2:0] onehot_digit(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int p = 0; p < 8; p++) begin
      if (v[p]) begin
        idx = 3'(7 - p);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Synchronizer chain for one asynchronous line plus a rising-edge pulse
// taken from the last synchronized stage.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Synchronizer shift chain and delayed copy of the last stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign level = r_sync[STAGES-1];
  assign rise  = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/seg_rx.sv
// Receive-side decoder for the 74HC595 display link; rebuilds the 32-bit shown value.
// Optional SEG_RX_ERRCNT_EN adds a saturating count of rejected latches on err_cnt.
module seg_rx
  import seg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ds,
  input  logic        shclk,
  input  logic        stclk,
  output logic [31:0] value,
  output logic        frame_vld,
  output logic        seg_err,
  output logic [15:0] err_cnt
);

  logic w_ds, w_ds_rise_unused;
  logic w_sh_level_unused, w_sh_rise;
  logic w_st_level_unused, w_st_rise;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ds (
    .clk(clk), .rst_n(rst_n), .d(ds), .level(w_ds), .rise(w_ds_rise_unused)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sh (
    .clk(clk), .rst_n(rst_n), .d(shclk), .level(w_sh_level_unused), .rise(w_sh_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_st (
    .clk(clk), .rst_n(rst_n), .d(stclk), .level(w_st_level_unused), .rise(w_st_rise)
  );

  logic [WORD_W-1:0] r_sr;
  logic [4:0]        r_bitcnt;
  logic [7:0]        r_mask;
  u32                r_shadow;
  u32                r_value;
  logic              r_frame_vld;
  logic              r_seg_err;

  logic [WORD_W-1:0] w_sr_nxt;
  logic [4:0]        w_cnt_nxt;
  logic [7:0]        w_segdata;
  logic [7:0]        w_segbit;
  logic [4:0]        w_hitnib;
  logic [2:0]        w_idx;
  logic              w_accept;
  u32                w_shadow_upd;
  logic [7:0]        w_mask_upd;

  // Shift happens before a same-cycle latch sees the word
  always_comb begin
    w_sr_nxt  = r_sr;
    w_cnt_nxt = r_bitcnt;
    if (w_sh_rise) begin
      w_sr_nxt  = {r_sr[WORD_W-2:0], w_ds};
      w_cnt_nxt = (r_bitcnt == 5'd31) ? 5'd31 : r_bitcnt + 5'd1;
    end else begin
      w_sr_nxt  = r_sr;
      w_cnt_nxt = r_bitcnt;
    end
  end

  // Word decode: first bit shifted in is segdata[0], so fields are bit-reversed
  always_comb begin
    w_segdata = 8'd0;
    w_segbit  = 8'd0;
    for (int j = 0; j < 8; j++) begin
      w_segdata[j] = w_sr_nxt[15-j];
      w_segbit[j]  = w_sr_nxt[7-j];
    end
    w_hitnib     = seg2nib(w_segdata);
    w_idx        = onehot_digit(w_segbit);
    w_accept     = (w_cnt_nxt == 5'd16) & is_onehot8(w_segbit) & w_hitnib[4];
    w_shadow_upd = r_shadow;
    w_shadow_upd[{w_idx, 2'b00} +: 4] = w_hitnib[3:0];
    w_mask_upd   = r_mask | (8'd1 << w_idx);
  end

  // Shift register, digit collection and frame completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr        <= '0;
      r_bitcnt    <= 5'd0;
      r_mask      <= 8'd0;
      r_shadow    <= 32'd0;
      r_value     <= 32'd0;
      r_frame_vld <= 1'b0;
      r_seg_err   <= 1'b0;
    end else begin
      r_sr        <= w_sr_nxt;
      r_frame_vld <= 1'b0;
      r_seg_err   <= 1'b0;
      if (w_st_rise) begin
        r_bitcnt <= 5'd0;
        if (w_accept) begin
          r_shadow <= w_shadow_upd;
          if (w_mask_upd == 8'hFF) begin
            r_value     <= w_shadow_upd;
            r_frame_vld <= 1'b1;
            r_mask      <= 8'd0;
          end else begin
            r_mask <= w_mask_upd;
          end
        end else begin
          r_seg_err <= 1'b1;
          r_mask    <= 8'd0;
        end
      end else begin
        r_bitcnt <= w_cnt_nxt;
      end
    end
  end

`ifdef SEG_RX_ERRCNT_EN
  logic [15:0] r_err_cnt;

  // Saturating rejected-latch counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 16'd0;
    end else if (r_seg_err && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 16'd0;
`endif

  assign value     = r_value;
  assign frame_vld = r_frame_vld;
  assign seg_err   = r_seg_err;

endmodule
